// File: rtl/count_wrap_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_mon_pkg
// Brief    : Event encodings and FIFO entry type for count_wrap_monitor.
//            CNT_MON_STAMP_EN adds a timestamp field to each entry.
// Revision : 1.0
// ============================================================================
package cnt_mon_pkg;

    localparam logic [1:0] c_evt_none    = 2'b00;
    localparam logic [1:0] c_evt_wrap_up = 2'b01;
    localparam logic [1:0] c_evt_wrap_dn = 2'b10;
    localparam logic [1:0] c_evt_jump    = 2'b11;

    localparam int c_stamp_w = 8;

    typedef enum logic [1:0] {
        NONE    = c_evt_none,
        WRAP_UP = c_evt_wrap_up,
        WRAP_DN = c_evt_wrap_dn,
        JUMP    = c_evt_jump
    } evt_type_t;

`ifdef CNT_MON_STAMP_EN
    typedef struct packed {
        evt_type_t              typ;
        logic [c_stamp_w-1:0]   stamp;
    } evt_entry_t;
`else
    typedef struct packed {
        evt_type_t              typ;
    } evt_entry_t;
`endif

endpackage

`default_nettype wire

// File: rtl/count_wrap_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : count_wrap_monitor_if
// Brief    : Event drain interface (valid/ready plus head data and level).
// Revision : 1.0
// ============================================================================
interface count_wrap_monitor_if #(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 8
) ();

    logic                     evt_valid;
    logic                     evt_ready;
    logic [1:0]               evt_type;
    logic [STAMP_W-1:0]       evt_stamp;
    logic [$clog2(DEPTH):0]   evt_level;

    modport master (
        output evt_valid,
        output evt_type,
        output evt_stamp,
        output evt_level,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_type,
        input  evt_stamp,
        input  evt_level,
        output evt_ready
    );

endinterface

`default_nettype wire

// File: rtl/count_wrap_monitor_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cnt_mon_fifo
// Brief    : Show-ahead synchronous FIFO of evt_entry_t, DEPTH entries.
// Revision : 1.0
// ============================================================================
module cnt_mon_fifo
    import cnt_mon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  evt_entry_t              push_data,
    input  logic                    pop,
    output evt_entry_t              head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_depth = LW'(DEPTH);

    evt_entry_t         mem_q [DEPTH];
    evt_entry_t         mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q,  level_d;
    logic               w_wr_en;
    logic               w_rd_en;

    assign empty   = (level_q == '0);
    assign full    = (level_q == c_depth);
    assign w_rd_en = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr_en = push && (!full || w_rd_en);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_wr_en, w_rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_wrap_monitor
// Brief    : Classifies count transitions (wrap-up, wrap-down, jump) and
//            queues them for a valid/ready consumer. Define CNT_MON_STAMP_EN
//            to attach a free-running cycle timestamp to each event.
// Revision : 1.0
// ============================================================================
module count_wrap_monitor
    import cnt_mon_pkg::*;
#(
    parameter int CNT_W   = 3,
    parameter int DEPTH   = 4,
    parameter int STAMP_W = c_stamp_w
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [CNT_W-1:0]        cnt_in,
    count_wrap_monitor_if.master    evt_if,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam logic [CNT_W-1:0] c_max = '1;
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic                   primed_q, primed_d;
    logic [CNT_W-1:0]       prev_q,   prev_d;
    logic                   ovf_q,    ovf_d;

    evt_type_t              w_evt;
    evt_entry_t             w_entry;
    evt_entry_t             w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_level;

    always_comb begin
        w_evt = NONE;
        if (primed_q) begin
            if (cnt_in == prev_q) begin
                w_evt = NONE;
            end else if (prev_q == c_max && cnt_in == '0) begin
                w_evt = WRAP_UP;
            end else if (prev_q == '0 && cnt_in == c_max) begin
                w_evt = WRAP_DN;
            end else if (prev_q != c_max && cnt_in == prev_q + c_one) begin
                w_evt = NONE;
            end else if (prev_q != '0 && cnt_in == prev_q - c_one) begin
                w_evt = NONE;
            end else begin
                w_evt = JUMP;
            end
        end
    end

`ifdef CNT_MON_STAMP_EN
    logic [STAMP_W-1:0] stamp_q, stamp_d;

    assign stamp_d = stamp_q + STAMP_W'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_d;
        end
    end
`endif

    always_comb begin
        w_entry     = '0;
        w_entry.typ = w_evt;
`ifdef CNT_MON_STAMP_EN
        w_entry.stamp = stamp_q;
`endif
    end

    assign w_push = (w_evt != NONE);
    assign w_pop  = !w_empty && evt_if.evt_ready;
    assign w_drop = w_push && w_full && !w_pop;

    cnt_mon_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (w_push),
        .push_data  (w_entry),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .level      (w_level)
    );

    // The first edge after reset only captures a reference value.
    always_comb begin
        primed_d = 1'b1;
        prev_d   = cnt_in;
        ovf_d    = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            primed_q <= 1'b0;
            prev_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            primed_q <= primed_d;
            prev_q   <= prev_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ovf              = ovf_q;
    assign evt_if.evt_valid = !w_empty;
    assign evt_if.evt_type  = w_empty ? c_evt_none : w_head.typ;
    assign evt_if.evt_level = w_level;
`ifdef CNT_MON_STAMP_EN
    assign evt_if.evt_stamp = w_empty ? '0 : w_head.stamp;
`else
    assign evt_if.evt_stamp = {STAMP_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_wrap_monitor
// Brief    : Directed self-checking bench for count_wrap_monitor.
// Revision : 1.0
// ============================================================================
module tb_count_wrap_monitor;

`ifdef CNT_MON_STAMP_EN
    localparam bit STAMP_ON = 1'b1;
`else
    localparam bit STAMP_ON = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic [2:0] cnt_in;
    logic       ovf;
    logic       ovf_clr;
    int         tests  = 0;
    int         failed = 0;

    count_wrap_monitor_if #(.DEPTH(4), .STAMP_W(8)) evt_if ();

    count_wrap_monitor #(
        .CNT_W   (3),
        .DEPTH   (4),
        .STAMP_W (8)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .cnt_in  (cnt_in),
        .evt_if  (evt_if),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges then one priming edge; stamp counter reads 1 afterwards.
    task automatic do_reset(input logic [2:0] start);
        rstn = 1'b0; cnt_in = start; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; cnt_in = 3'd7; ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
        tick(); tick();
        tests++; if (evt_if.evt_valid !== 1'b0) begin failed++; $display("FAIL rst_valid: got %b expected 0", evt_if.evt_valid); end
        tests++; if (evt_if.evt_level !== 3'd0) begin failed++; $display("FAIL rst_level: got %0d expected 0", evt_if.evt_level); end
        tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        tests++; if (evt_if.evt_type !== 2'b00) begin failed++; $display("FAIL rst_type: got %b expected 00", evt_if.evt_type); end
        tests++; if (evt_if.evt_stamp !== 8'd0) begin failed++; $display("FAIL rst_stamp: got %0d expected 0", evt_if.evt_stamp); end
        rstn = 1'b1;
        tick();
        tests++; if (evt_if.evt_valid !== 1'b0) begin failed++; $display("FAIL prime_no_event: got %b expected 0", evt_if.evt_valid); end
        tick();
        tests++; if (evt_if.evt_level !== 3'd0) begin failed++; $display("FAIL empty_pop_level: got %0d expected 0", evt_if.evt_level); end
    endtask

    task automatic test_wrap_up();
        do_reset(3'd5);
        evt_if.evt_ready = 1'b1;
        cnt_in = 3'd6; tick();
        cnt_in = 3'd7; tick();
        tests++; if (evt_if.evt_valid !== 1'b0) begin failed++; $display("FAIL wu_step_quiet: got %b expected 0", evt_if.evt_valid); end
        cnt_in = 3'd0; tick();
        tests++; if (evt_if.evt_valid !== 1'b1) begin failed++; $display("FAIL wu_valid: got %b expected 1", evt_if.evt_valid); end
        tests++; if (evt_if.evt_type !== 2'b01) begin failed++; $display("FAIL wu_type: got %b expected 01", evt_if.evt_type); end
        tests++; if (evt_if.evt_stamp !== (STAMP_ON ? 8'd3 : 8'd0)) begin failed++; $display("FAIL wu_stamp: got %0d expected %0d", evt_if.evt_stamp, STAMP_ON ? 3 : 0); end
        cnt_in = 3'd1; tick();
        tests++; if (evt_if.evt_valid !== 1'b0) begin failed++; $display("FAIL wu_one_cycle: got %b expected 0", evt_if.evt_valid); end
    endtask

    task automatic test_wrap_dn();
        do_reset(3'd2);
        evt_if.evt_ready = 1'b1;
        cnt_in = 3'd1; tick();
        cnt_in = 3'd0; tick();
        cnt_in = 3'd7; tick();
        tests++; if (evt_if.evt_type !== 2'b10 || evt_if.evt_valid !== 1'b1) begin failed++; $display("FAIL wd_type: got valid=%b type=%b expected valid=1 type=10", evt_if.evt_valid, evt_if.evt_type); end
        tests++; if (evt_if.evt_stamp !== (STAMP_ON ? 8'd3 : 8'd0)) begin failed++; $display("FAIL wd_stamp: got %0d expected %0d", evt_if.evt_stamp, STAMP_ON ? 3 : 0); end
        cnt_in = 3'd6; tick();
        tests++; if (evt_if.evt_valid !== 1'b0) begin failed++; $display("FAIL wd_one_cycle: got %b expected 0", evt_if.evt_valid); end
    endtask

    task automatic test_jump();
        do_reset(3'd4);
        cnt_in = 3'd0; tick();
        tests++; if (evt_if.evt_type !== 2'b11 || evt_if.evt_valid !== 1'b1) begin failed++; $display("FAIL jump_type: got valid=%b type=%b expected valid=1 type=11", evt_if.evt_valid, evt_if.evt_type); end
        tests++; if (evt_if.evt_stamp !== (STAMP_ON ? 8'd1 : 8'd0)) begin failed++; $display("FAIL jump_stamp: got %0d expected %0d", evt_if.evt_stamp, STAMP_ON ? 1 : 0); end
        evt_if.evt_ready = 1'b1; tick();
        tests++; if (evt_if.evt_valid !== 1'b0) begin failed++; $display("FAIL jump_popped: got %b expected 0", evt_if.evt_valid); end
    endtask

    task automatic test_hold_and_step();
        int seen = 0;
        do_reset(3'd3);
        evt_if.evt_ready = 1'b1;
        repeat (10) begin
            tick();
            if (evt_if.evt_valid !== 1'b0) seen++;
        end
        tests++; if (seen != 0) begin failed++; $display("FAIL hold_quiet: got %0d events expected 0", seen); end
        seen = 0;
        foreach (cnt_in[i]) begin end
        cnt_in = 3'd4; tick(); if (evt_if.evt_valid !== 1'b0) seen++;
        cnt_in = 3'd5; tick(); if (evt_if.evt_valid !== 1'b0) seen++;
        cnt_in = 3'd4; tick(); if (evt_if.evt_valid !== 1'b0) seen++;
        cnt_in = 3'd3; tick(); if (evt_if.evt_valid !== 1'b0) seen++;
        cnt_in = 3'd2; tick(); if (evt_if.evt_valid !== 1'b0) seen++;
        tests++; if (seen != 0) begin failed++; $display("FAIL unit_steps_quiet: got %0d events expected 0", seen); end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_t [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_s [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_reset(3'd7);
        for (int i = 0; i < 4; i++) begin
            cnt_in = (i % 2 == 0) ? 3'd0 : 3'd7;
            tick();
        end
        tests++; if (evt_if.evt_level !== 3'd4 || ovf !== 1'b0) begin failed++; $display("FAIL ovf_fill: got level=%0d ovf=%b expected level=4 ovf=0", evt_if.evt_level, ovf); end
        cnt_in = 3'd0; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        tests++; if (evt_if.evt_level !== 3'd4 || ovf !== 1'b1) begin failed++; $display("FAIL ovf_drop: got level=%0d ovf=%b expected level=4 ovf=1", evt_if.evt_level, ovf); end
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_type !== exp_t[i] || evt_if.evt_stamp !== (STAMP_ON ? exp_s[i] : 8'd0)) begin
                failed++;
                $display("FAIL ovf_drain[%0d]: got v=%b t=%b s=%0d expected v=1 t=%b s=%0d", i, evt_if.evt_valid, evt_if.evt_type, evt_if.evt_stamp, exp_t[i], STAMP_ON ? exp_s[i] : 8'd0);
            end
            tick();
        end
        tests++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_level !== 3'd0 || ovf !== 1'b1) begin failed++; $display("FAIL ovf_drained: got v=%b level=%0d ovf=%b expected v=0 level=0 ovf=1", evt_if.evt_valid, evt_if.evt_level, ovf); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
    endtask

    task automatic test_full_push_pop();
        logic [1:0] exp_t [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [7:0] exp_s [4] = '{8'd2, 8'd3, 8'd4, 8'd5};
        do_reset(3'd7);
        for (int i = 0; i < 4; i++) begin
            cnt_in = (i % 2 == 0) ? 3'd0 : 3'd7;
            tick();
        end
        cnt_in = 3'd0; evt_if.evt_ready = 1'b1; tick();
        tests++; if (evt_if.evt_level !== 3'd4 || ovf !== 1'b0) begin failed++; $display("FAIL fpp_level: got level=%0d ovf=%b expected level=4 ovf=0", evt_if.evt_level, ovf); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_type !== exp_t[i] || evt_if.evt_stamp !== (STAMP_ON ? exp_s[i] : 8'd0)) begin
                failed++;
                $display("FAIL fpp_drain[%0d]: got v=%b t=%b s=%0d expected v=1 t=%b s=%0d", i, evt_if.evt_valid, evt_if.evt_type, evt_if.evt_stamp, exp_t[i], STAMP_ON ? exp_s[i] : 8'd0);
            end
            tick();
        end
        tests++; if (evt_if.evt_valid !== 1'b0) begin failed++; $display("FAIL fpp_empty: got %b expected 0", evt_if.evt_valid); end
    endtask

    task automatic test_reset_midstream();
        do_reset(3'd7);
        for (int i = 0; i < 5; i++) begin
            cnt_in = (i % 2 == 0) ? 3'd0 : 3'd7;
            tick();
        end
        evt_if.evt_ready = 1'b1; tick(); evt_if.evt_ready = 1'b0;
        tests++; if (evt_if.evt_level !== 3'd3 || ovf !== 1'b1) begin failed++; $display("FAIL mid_pre: got level=%0d ovf=%b expected level=3 ovf=1", evt_if.evt_level, ovf); end
        rstn = 1'b0; tick();
        tests++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_level !== 3'd0 || ovf !== 1'b0) begin failed++; $display("FAIL mid_reset: got v=%b level=%0d ovf=%b expected v=0 level=0 ovf=0", evt_if.evt_valid, evt_if.evt_level, ovf); end
        tests++; if (evt_if.evt_type !== 2'b00 || evt_if.evt_stamp !== 8'd0) begin failed++; $display("FAIL mid_head: got t=%b s=%0d expected t=00 s=0", evt_if.evt_type, evt_if.evt_stamp); end
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; cnt_in = 3'd0; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
        test_reset();
        test_wrap_up();
        test_wrap_dn();
        test_jump();
        test_hold_and_step();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Sits directly downstream of the 3-bit up/down counter and consumes its count output every clock.
- Classifies each count transition:
  - wrap-up: MAX to 0
  - wrap-down: 0 to MAX
  - jump: any non-unit change
- Each classified event is pushed, with an optional timestamp, into a small FIFO.
- A consumer drains the FIFO over a valid/ready handshake.

Parameters:
- CNT_W, 3, width of monitored count; MAX = 2**CNT_W-1
- DEPTH, 4, event FIFO entries; power of 2, >=2
- STAMP_W, 8, timestamp width (free-running cycle counter)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  reset; synchronous, active-low
- cnt_in  in  CNT_W  count value from the upstream counter
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head this cycle
- evt_type  out  2  head event type
- evt_stamp  out  STAMP_W  head event timestamp
- evt_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- ovf  out  1  sticky flag: an event was dropped
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (rstn=0 at a rising edge): all of the following are cleared.
  - FIFO emptied: evt_valid=0, evt_level=0.
  - ovf=0, stamp counter=0, primed=0, prev register=0.
  - evt_type=0 and evt_stamp=0 while empty.
- Primed: the first edge after reset release loads prev<=cnt_in and sets primed=1. No event is generated on that edge.
- Every edge while primed: compare cnt_in with prev, then prev<=cnt_in. Classification:
  - cnt_in==prev: none (hold)
  - cnt_in==prev+1 with prev!=MAX, or cnt_in==prev-1 with prev!=0: none (normal step)
  - prev==MAX and cnt_in==0: WRAP_UP = 2'b01
  - prev==0 and cnt_in==MAX: WRAP_DN = 2'b10
  - anything else: JUMP = 2'b11; covers the upstream counter being reset mid-count
- Push: on the same edge that cnt_in is compared. Entry = {type, stamp value at that edge}.
  - Latency: evt_valid rises the cycle after cnt_in first shows the new value.
- FIFO: show-ahead.
  - evt_type and evt_stamp reflect the head combinationally from storage while evt_valid=1.
  - Pop occurs when evt_valid && evt_ready.
- Full, push without pop: event dropped, ovf<=1, level unchanged.
- Full, push with pop on the same edge: both happen, no drop, level unchanged.
- Empty, pop attempt: ignored, because evt_valid=0.
- ovf_clr together with a drop on the same edge: set wins, ovf stays 1.
- Stamp counter: increments every edge after reset and wraps 2**STAMP_W-1 -> 0.
- evt_valid holds high and head data stays stable until popped; no retraction.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: CNT_MON_STAMP_EN.
- Defined: stamp counter instantiated, timestamp stored per entry, evt_stamp driven from the head.
- Undefined: no stamp counter or stamp storage. evt_stamp port kept but tied to 0. All other behaviour identical.

Decomposition:
- Package cnt_mon_pkg:
  - evt_type_t enum: NONE=0, WRAP_UP=1, WRAP_DN=2, JUMP=3
  - packed struct evt_entry_t: {type, stamp}
  - localparams for the encodings
- One sub-module, cnt_mon_fifo:
  - generic synchronous FIFO of evt_entry_t, DEPTH entries
  - synchronous active-low reset; push, pop, full, empty, level
- Top module: primed/prev logic, classifier, stamp counter, ovf.

Test Plan:
- Up-count 5,6,7,0,1 with evt_ready=1 -> exactly one WRAP_UP; evt_valid high for 1 cycle, starting the cycle after cnt_in=0.
- Down-count 2,1,0,7,6 -> one WRAP_DN; stamp = previous stamp + 3 cycles relative to the first cnt_in=0 edge (with CNT_MON_STAMP_EN).
- Count 4 then 0 (upstream reset) -> one JUMP. Hold at 3 for 10 cycles -> no events. First cycle after own reset with cnt_in=7 -> no event.
- evt_ready=0, generate 5 wraps with DEPTH=4 -> evt_level=4, ovf=1, drained order = first 4 events. Then ovf_clr -> ovf=0.
- Full FIFO with evt_ready=1 and a new wrap on the same edge -> level stays 4, ovf stays 0, new event appears at the tail.
- rstn=0 with 3 entries queued -> next cycle evt_valid=0, level=0, ovf=0. Rebuild CNT_MON_STAMP_EN undefined -> evt_stamp always 0.
